case_conv_sched: RTL and testbench
==================================

Name: case_conv_sched

Overview:
Packet-level round-robin scheduler that shares one ASCII case-conversion datapath between NREQ byte-stream requesters. It selects a requester and holds the grant for a whole packet, which ends on a byte with last=1. Each byte passes through the converter into a single registered output stage with a valid/ready handshake. The block also tags each output byte with its source and keeps a saturating count of bytes actually modified.

Parameters:
NREQ, 2, number of requesters (2..8)
IDW, 1, width of source-ID tag; must satisfy 2**IDW >= NREQ
CNTW, 16, width of modified-byte counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester byte valid
req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NREQ  per-requester end-of-packet flag
req_ready  out  NREQ  per-requester accept
mode  in  2  conversion mode: 00 pass, 01 upper, 10 lower, 11 toggle-case
out_valid  out  1  output byte valid
out_data  out  8  converted byte
out_last  out  1  end of packet
out_id  out  IDW  index of the source requester
out_ready  in  1  downstream accept
busy  out  1  high while a packet is locked
mod_count  out  CNTW  saturating count of bytes where out_data != input byte

Behaviour:
- Reset values: out_valid=0, out_data=0, out_last=0, out_id=0, busy=0, mod_count=0, rr_ptr=0, state=IDLE, req_ready=0.
- Reset asserted mid-packet aborts the packet at once. The held output byte is dropped. No partial state survives.
- FSM state IDLE: search requesters starting at rr_ptr, wrapping modulo NREQ. The first with req_valid=1 is latched as owner. Current mode is latched as pkt_mode. Next state is LOCKED, and busy=1 from the next cycle. No byte is accepted in the grant cycle, so the grant decision costs 1 cycle.
- FSM state LOCKED:
  - req_ready[owner] = !out_valid || out_ready. All other req_ready bits are 0.
  - A transfer occurs when req_valid[owner] && req_ready[owner].
  - On a transfer, the output register loads the converted byte, req_last and owner, and out_valid=1 on the next cycle.
  - Latency is 1 cycle from accept to out_valid. Full throughput is 1 byte/cycle while out_ready=1.
  - When the accepted byte has last=1: next state is IDLE, rr_ptr = (owner+1) mod NREQ, busy=0.
- Output handshake:
  - out_valid clears when out_ready=1 and no new transfer occurs that cycle.
  - out_data, out_last and out_id are stable while out_valid=1 and out_ready=0.
- Conversion is by exact range check, never by bit pattern alone:
  - upper: 0x61..0x7A map to byte-0x20.
  - lower: 0x41..0x5A map to byte+0x20.
  - toggle: apply whichever of the two rules fits.
  - All other bytes, including 0x40, 0x5B, 0x60, 0x7B and >=0x80, pass unchanged.
- mode changes during LOCKED are ignored until the next packet.
- mod_count increments by 1 on each transfer whose converted byte differs from the input byte. It holds at all-ones and never wraps.
- Simultaneous requests in IDLE: the requester nearest to rr_ptr wins. A single requester that is continuously valid is re-granted after every packet, at a cost of 1 idle cycle each time.
- Owner drops req_valid mid-packet: the grant is kept indefinitely. There is no timeout.

Decomposition:
- Shared package case_conv_pkg holds:
  - the mode encodings MODE_PASS, MODE_UPPER, MODE_LOWER, MODE_TOGGLE;
  - constants ASCII_a=0x61, ASCII_z=0x7A, ASCII_A=0x41, ASCII_Z=0x5A, CASE_BIT=0x20;
  - the FSM state enum IDLE/LOCKED.
- One sub-module, case_conv_core: purely combinational; inputs byte and mode; outputs converted byte and a changed flag. It is instantiated once in the scheduler.

Test Plan:
- Reset mid-packet: rst=1 while out_valid=1 -> next cycle out_valid=0, busy=0, mod_count=0, rr_ptr=0; a new packet from requester 1 is granted normally.
- Upper conversion and latency: mode=01, req0 sends "a{z@" (0x61,0x7B,0x7A,0x40) with last on the final byte, out_ready=1 -> outputs 0x41,0x7B,0x5A,0x40 on consecutive cycles starting 1 cycle after each accept; out_id=0; mod_count=2; IDLE afterwards.
- Round-robin fairness: both requesters continuously valid with 2-byte packets -> grants alternate 0,1,0,1; each packet boundary shows exactly 1 idle cycle.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data held constant, req_ready[owner]=0; on release, bytes continue with none dropped or duplicated.
- Mode latch and toggle: start packet with mode=11 sending 0x41,0x62; switch mode to 00 mid-packet -> outputs 0x61,0x42.
- Counter saturation: CNTW=2, mode=01, send five 0x61 bytes -> mod_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/case_conv_pkg.sv
// rtl/case_conv_pkg.sv - shared constants and types for the case-conversion scheduler
package case_conv_pkg;

   // conversion mode encodings
   localparam logic [1:0] MODE_PASS   = 2'b00;
   localparam logic [1:0] MODE_UPPER  = 2'b01;
   localparam logic [1:0] MODE_LOWER  = 2'b10;
   localparam logic [1:0] MODE_TOGGLE = 2'b11;

   // ASCII letter range bounds and the case offset between them
   localparam logic [7:0] ASCII_a  = 8'h61;
   localparam logic [7:0] ASCII_z  = 8'h7A;
   localparam logic [7:0] ASCII_A  = 8'h41;
   localparam logic [7:0] ASCII_Z  = 8'h5A;
   localparam logic [7:0] CASE_BIT = 8'h20;

   // scheduler states
   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

endpackage

// File: rtl/case_conv_core.sv
// rtl/case_conv_core.sv - combinational ASCII case converter with changed flag
module case_conv_core
   import case_conv_pkg::*;
(
   input  logic [7:0] data,
   input  logic [1:0] mode,
   output logic [7:0] conv,
   output logic       changed
);

   logic is_lc;
   logic is_uc;

   // letters are recognised by exact range, so punctuation next to the
   // alphabet (0x40, 0x5B, 0x60, 0x7B) and high bytes never get touched
   always_comb begin
      is_lc = (data >= ASCII_a) && (data <= ASCII_z);
      is_uc = (data >= ASCII_A) && (data <= ASCII_Z);
      conv  = data;
      case (mode)
         MODE_PASS:   conv = data;
         MODE_UPPER:  if (is_lc) conv = data - CASE_BIT;
         MODE_LOWER:  if (is_uc) conv = data + CASE_BIT;
         MODE_TOGGLE: begin
            if (is_lc)      conv = data - CASE_BIT;
            else if (is_uc) conv = data + CASE_BIT;
         end
         default:     conv = data;
      endcase
      changed = (conv != data);
   end

endmodule

// File: rtl/case_conv_sched.sv
// rtl/case_conv_sched.sv - packet round-robin scheduler sharing one case converter
module case_conv_sched
   import case_conv_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = 1,
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   input  logic [1:0]        mode,
   output logic              out_valid,
   output logic [7:0]        out_data,
   output logic              out_last,
   output logic [IDW-1:0]    out_id,
   input  logic              out_ready,
   output logic              busy,
   output logic [CNTW-1:0]   mod_count
);

   state_t          state;
   logic [IDW-1:0]  owner;
   logic [IDW-1:0]  rr_ptr;
   logic [1:0]      pkt_mode;

   logic            grant_found;
   logic [IDW-1:0]  grant_idx;
   logic [IDW-1:0]  next_ptr;

   logic            own_valid;
   logic            own_last;
   logic [7:0]      own_data;
   logic [7:0]      conv_data;
   logic            conv_changed;
   logic            xfer;

   assign own_valid = req_valid[owner];
   assign own_last  = req_last[owner];
   assign own_data  = req_data[{owner, 3'b000} +: 8];
   assign xfer      = (state == LOCKED) && own_valid && req_ready[owner];
   assign next_ptr  = (owner == IDW'(NREQ - 1)) ? '0 : owner + IDW'(1);

   // only the owner may be accepted, and only when the output stage can take a byte
   always_comb begin
      req_ready = '0;
      if (state == LOCKED) req_ready[owner] = !out_valid || out_ready;
   end

   // find the first valid requester at or after rr_ptr, wrapping around
   always_comb begin
      int sum;
      sum         = 0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = int'(rr_ptr) + k;
         if (sum >= NREQ) sum = sum - NREQ;
         if (!grant_found && req_valid[IDW'(sum)]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(sum);
         end
      end
   end

   case_conv_core u_core (
      .data    (own_data),
      .mode    (pkt_mode),
      .conv    (conv_data),
      .changed (conv_changed)
   );

   // grant FSM: latch owner and mode in IDLE, release after the last byte
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         pkt_mode <= MODE_PASS;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  owner    <= grant_idx;
                  pkt_mode <= mode;
                  state    <= LOCKED;
                  busy     <= 1'b1;
               end
            end
            LOCKED: begin
               if (xfer && own_last) begin
                  state  <= IDLE;
                  rr_ptr <= next_ptr;
                  busy   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // output register and saturating modified-byte counter
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_id    <= '0;
         mod_count <= '0;
      end else begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= conv_data;
            out_last  <= own_last;
            out_id    <= owner;
            if (conv_changed && (mod_count != {CNTW{1'b1}}))
               mod_count <= mod_count + CNTW'(1);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_case_conv_sched.sv
// tb/tb_case_conv_sched.sv - directed self-checking bench for case_conv_sched
module tb_case_conv_sched;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [15:0] req_data;
   logic [1:0]  req_last;
   logic [1:0]  req_ready;
   logic [1:0]  mode;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic [0:0]  out_id;
   logic        out_ready;
   logic        busy;
   logic [15:0] mod_count;

   logic [1:0]  s_req_ready;
   logic        s_out_valid;
   logic [7:0]  s_out_data;
   logic        s_out_last;
   logic [0:0]  s_out_id;
   logic        s_busy;
   logic [1:0]  s_mod_count;

   int total;
   int bad;

   case_conv_sched #(.NREQ(2), .IDW(1), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .mode(mode),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_id(out_id), .out_ready(out_ready), .busy(busy), .mod_count(mod_count)
   );

   case_conv_sched #(.NREQ(2), .IDW(1), .CNTW(2)) dut_sat (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(s_req_ready), .mode(mode),
      .out_valid(s_out_valid), .out_data(s_out_data), .out_last(s_out_last),
      .out_id(s_out_id), .out_ready(out_ready), .busy(s_busy), .mod_count(s_mod_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] mode;
      logic [7:0] din;
      logic [7:0] dout;
      int         chg;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int exp_cnt;
      int idx [2];
      logic [1:0] acc;
      logic [7:0] bp_bytes [4];
      logic [7:0] rcv [$];
      logic [7:0] held;
      logic       prev_stall;
      int         si;
      logic [7:0] rr_exp;
      logic [7:0] up_in [4];
      logic [7:0] up_out [4];

      total = 0;
      bad   = 0;

      vecs[0]  = '{2'b01, 8'h61, 8'h41, 1};
      vecs[1]  = '{2'b01, 8'h7A, 8'h5A, 1};
      vecs[2]  = '{2'b01, 8'h7B, 8'h7B, 0};
      vecs[3]  = '{2'b01, 8'h60, 8'h60, 0};
      vecs[4]  = '{2'b10, 8'h41, 8'h61, 1};
      vecs[5]  = '{2'b10, 8'h5A, 8'h7A, 1};
      vecs[6]  = '{2'b10, 8'h40, 8'h40, 0};
      vecs[7]  = '{2'b10, 8'h5B, 8'h5B, 0};
      vecs[8]  = '{2'b11, 8'h61, 8'h41, 1};
      vecs[9]  = '{2'b11, 8'h5A, 8'h7A, 1};
      vecs[10] = '{2'b11, 8'hE1, 8'hE1, 0};
      vecs[11] = '{2'b00, 8'h61, 8'h61, 0};
      vecs[12] = '{2'b11, 8'h80, 8'h80, 0};
      vecs[13] = '{2'b01, 8'h41, 8'h41, 0};

      mode      = 2'b00;
      out_ready = 1'b1;
      do_reset();

      // reset state
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_id", out_id, 0);
      check("rst_busy", busy, 0);
      check("rst_mod_count", mod_count, 0);
      check("rst_req_ready", req_ready, 0);

      // single-byte packets through the converter
      exp_cnt = 0;
      for (int i = 0; i < 14; i++) begin
         mode        = vecs[i].mode;
         req_valid   = 2'b01;
         req_data    = {8'h00, vecs[i].din};
         req_last    = 2'b01;
         tick();
         check("vec_busy", busy, 1);
         tick();
         req_valid = '0;
         exp_cnt   = exp_cnt + vecs[i].chg;
         check($sformatf("vec%0d_valid", i), out_valid, 1);
         check($sformatf("vec%0d_data", i), out_data, vecs[i].dout);
         check($sformatf("vec%0d_last", i), out_last, 1);
         check($sformatf("vec%0d_count", i), mod_count, exp_cnt);
         tick();
         check($sformatf("vec%0d_drain", i), out_valid, 0);
      end

      // upper conversion and latency: "a{z@"
      do_reset();
      up_in  = '{8'h61, 8'h7B, 8'h7A, 8'h40};
      up_out = '{8'h41, 8'h7B, 8'h5A, 8'h40};
      mode      = 2'b01;
      req_valid = 2'b01;
      req_data  = {8'h00, up_in[0]};
      req_last  = 2'b00;
      tick();
      check("up_grant_busy", busy, 1);
      check("up_grant_no_out", out_valid, 0);
      for (int i = 0; i < 4; i++) begin
         req_data = {8'h00, up_in[i]};
         req_last = {1'b0, (i == 3)};
         tick();
         check($sformatf("up%0d_valid", i), out_valid, 1);
         check($sformatf("up%0d_data", i), out_data, up_out[i]);
         check($sformatf("up%0d_id", i), out_id, 0);
         check($sformatf("up%0d_last", i), out_last, (i == 3));
      end
      req_valid = '0;
      check("up_count", mod_count, 2);
      check("up_idle", busy, 0);
      tick();
      check("up_drained", out_valid, 0);

      // reset mid-packet
      do_reset();
      mode      = 2'b01;
      req_valid = 2'b01;
      req_data  = 16'h0061;
      req_last  = 2'b00;
      tick();
      tick();
      check("mid_valid_before", out_valid, 1);
      check("mid_count_before", mod_count, 1);
      rst       = 1'b1;
      req_valid = '0;
      tick();
      check("mid_out_valid", out_valid, 0);
      check("mid_busy", busy, 0);
      check("mid_count", mod_count, 0);
      check("mid_rr_ptr", dut.rr_ptr, 0);
      rst       = 1'b0;
      req_valid = 2'b10;
      req_data  = 16'h6200;
      req_last  = 2'b10;
      tick();
      tick();
      req_valid = '0;
      check("mid_new_valid", out_valid, 1);
      check("mid_new_id", out_id, 1);
      check("mid_new_data", out_data, 8'h42);
      tick();

      // round robin with both requesters continuously valid
      do_reset();
      mode      = 2'b00;
      req_valid = 2'b11;
      idx[0]    = 0;
      idx[1]    = 0;
      for (int n = 1; n <= 12; n++) begin
         req_data = {8'h20 + 8'(idx[1]), 8'h10 + 8'(idx[0])};
         req_last = {(idx[1] == 1), (idx[0] == 1)};
         #1;
         acc = req_valid & req_ready;
         tick();
         for (int r = 0; r < 2; r++) if (acc[r]) idx[r] = 1 - idx[r];
         if ((n % 3) == 1) begin
            check($sformatf("rr%0d_gap", n), out_valid, 0);
         end else begin
            rr_exp = (((n - 2) / 3) % 2 == 0) ? 8'h10 : 8'h20;
            if ((n % 3) == 0) rr_exp = rr_exp + 8'h01;
            check($sformatf("rr%0d_valid", n), out_valid, 1);
            check($sformatf("rr%0d_id", n), out_id, ((n - 2) / 3) % 2);
            check($sformatf("rr%0d_data", n), out_data, rr_exp);
         end
      end
      req_valid = '0;
      tick();
      tick();

      // backpressure: three stalled cycles mid-packet
      do_reset();
      mode       = 2'b01;
      bp_bytes   = '{8'h61, 8'h62, 8'h63, 8'h64};
      si         = 0;
      prev_stall = 1'b0;
      held       = '0;
      for (int n = 0; n < 12; n++) begin
         out_ready = !(n >= 3 && n <= 5);
         req_valid = {1'b0, (si < 4)};
         req_data  = {8'h00, (si < 4) ? bp_bytes[si] : 8'h00};
         req_last  = {1'b0, (si == 3)};
         #1;
         if (prev_stall && out_valid)
            check($sformatf("bp%0d_hold", n), out_data, held);
         if (out_valid && !out_ready) begin
            check($sformatf("bp%0d_ready_low", n), req_ready[0], 0);
            held = out_data;
         end
         prev_stall = out_valid && !out_ready;
         if (out_valid && out_ready) rcv.push_back(out_data);
         acc = req_valid & req_ready;
         tick();
         if (acc[0]) si++;
      end
      check("bp_count", rcv.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < rcv.size()) check($sformatf("bp_byte%0d", i), rcv[i], bp_bytes[i] - 8'h20);
      req_valid = '0;
      out_ready = 1'b1;

      // mode latched at grant, toggle then switch to pass mid-packet
      do_reset();
      mode      = 2'b11;
      req_valid = 2'b01;
      req_data  = 16'h0041;
      req_last  = 2'b00;
      tick();
      tick();
      check("tog_first", out_data, 8'h61);
      mode     = 2'b00;
      req_data = 16'h0062;
      req_last = 2'b01;
      tick();
      req_valid = '0;
      check("tog_second", out_data, 8'h42);
      check("tog_last", out_last, 1);
      tick();

      // counter saturation on the narrow instance
      do_reset();
      mode      = 2'b01;
      req_valid = 2'b01;
      req_data  = 16'h0061;
      req_last  = 2'b00;
      tick();
      for (int i = 0; i < 5; i++) begin
         req_last = {1'b0, (i == 4)};
         tick();
         check($sformatf("sat%0d_narrow", i), s_mod_count, (i < 3) ? i + 1 : 3);
         check($sformatf("sat%0d_wide", i), mod_count, i + 1);
      end
      req_valid = '0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
